// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin arbiter in front of a single register-file write port.
// Grants are combinational; the winning write is registered and presented one cycle later.
module rf_write_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  r0_valid,
  input  logic [ADDR_LEN-1:0]   r0_dest,
  input  logic [WORD_WIDTH-1:0] r0_data,
  output logic                  r0_ready,
  input  logic                  r1_valid,
  input  logic [ADDR_LEN-1:0]   r1_dest,
  input  logic [WORD_WIDTH-1:0] r1_data,
  output logic                  r1_ready,
  output logic                  wr_en,
  output logic [ADDR_LEN-1:0]   wr_dest,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  prio,
  output logic [7:0]            conflict_cnt
);

  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic                  grant0;
  logic                  grant1;
  logic                  arb_open;
  logic                  contend;

  logic                  prio_q,    prio_d;
  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_LEN-1:0]   wr_dest_q, wr_dest_d;
  logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [7:0]            cnt_q,     cnt_d;

  // Reset gates the grant path too, so nothing is accepted while rst is high.
  assign arb_open = !rst && !hold;
  assign contend  = arb_open && r0_valid && r1_valid;
  assign grant0   = arb_open && r0_valid && (!r1_valid || (prio_q == 1'b0));
  assign grant1   = arb_open && r1_valid && (!r0_valid || (prio_q == 1'b1));

  assign r0_ready     = grant0;
  assign r1_ready     = grant1;
  assign wr_en        = wr_en_q;
  assign wr_dest      = wr_dest_q;
  assign wr_data      = wr_data_q;
  assign prio         = prio_q;
  assign conflict_cnt = cnt_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    prio_d    = prio_q;
    wr_en_d   = 1'b0;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;

    if (grant0) begin
      wr_en_d   = 1'b1;
      wr_dest_d = r0_dest;
      wr_data_d = r0_data;
      prio_d    = 1'b1;
    end else if (grant1) begin
      wr_en_d   = 1'b1;
      wr_dest_d = r1_dest;
      wr_data_d = r1_data;
      prio_d    = 1'b0;
    end

    if (contend && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      prio_q    <= prio_d;
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  one_grant_a : assert property (@(posedge clk) disable iff (rst) !(r0_ready && r1_ready))
    else $error("both requesters granted in one cycle");

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a rule-level reference model.
module tb_rf_write_arbiter;

  localparam int WW = 32;
  localparam int AL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hold = 1'b0;
  logic          r0_valid = 1'b0, r1_valid = 1'b0;
  logic [AL-1:0] r0_dest = '0, r1_dest = '0;
  logic [WW-1:0] r0_data = '0, r1_data = '0;
  logic          r0_ready, r1_ready;
  logic          wr_en;
  logic [AL-1:0] wr_dest;
  logic [WW-1:0] wr_data;
  logic          prio;
  logic [7:0]    conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            prio_m;
  int            cnt_m;
  bit            wr_en_m;
  logic [AL-1:0] wr_dest_m;
  logic [WW-1:0] wr_data_m;
  logic [WW-1:0] rf_m   [16];
  logic [WW-1:0] rf_dut [16];

  rf_write_arbiter #(.WORD_WIDTH(WW), .ADDR_LEN(AL)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .r0_valid(r0_valid), .r0_dest(r0_dest), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_dest(r1_dest), .r1_data(r1_data), .r1_ready(r1_ready),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data),
    .prio(prio), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT's write port; a write lands at the edge after wr_en rises.
  always @(posedge clk) begin
    if (wr_en === 1'b1) rf_dut[wr_dest] = wr_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    prio_m    = 0;
    cnt_m     = 0;
    wr_en_m   = 1'b0;
    wr_dest_m = '0;
    wr_data_m = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".wr_en"},   wr_en,        wr_en_m);
    check({tag, ".wr_dest"}, wr_dest,      wr_dest_m);
    check({tag, ".wr_data"}, wr_data,      wr_data_m);
    check({tag, ".prio"},    prio,         prio_m[0]);
    check({tag, ".cnt"},     conflict_cnt, cnt_m);
  endtask

  // One clock cycle: present inputs, check grants, then check registered results.
  task automatic drive(input string tag, input bit h,
                       input bit v0, input logic [AL-1:0] d0, input logic [WW-1:0] x0,
                       input bit v1, input logic [AL-1:0] d1, input logic [WW-1:0] x1,
                       output int win);
    @(negedge clk);
    hold = h;
    r0_valid = v0; r0_dest = d0; r0_data = x0;
    r1_valid = v1; r1_dest = d1; r1_data = x1;
    win = -1;
    if (!h) begin
      if (v0 && v1)  win = prio_m;
      else if (v0)   win = 0;
      else if (v1)   win = 1;
    end
    #1;
    check({tag, ".r0_ready"}, r0_ready, win == 0);
    check({tag, ".r1_ready"}, r1_ready, win == 1);
    @(posedge clk);
    #1;
    if (wr_en_m) rf_m[wr_dest_m] = wr_data_m;
    if (!h && v0 && v1 && cnt_m < 255) cnt_m++;
    wr_en_m = (win >= 0);
    if (win == 0) begin wr_dest_m = d0; wr_data_m = x0; prio_m = 1; end
    if (win == 1) begin wr_dest_m = d1; wr_data_m = x1; prio_m = 0; end
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    int w;
    for (int i = 0; i < n; i++) drive("idle", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, w);
  endtask

  // Reset with both requests presented; nothing may be accepted.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    r0_valid = 1'b1; r0_dest = 4'd9;  r0_data = 32'hDEAD;
    r1_valid = 1'b1; r1_dest = 4'd10; r1_data = 32'hBEEF;
    model_reset();
    #1;
    check("rst.r0_ready", r0_ready, 1'b0);
    check("rst.r1_ready", r1_ready, 1'b0);
    check_outputs("rst");
    @(posedge clk);
    #1;
    check_outputs("rst_edge");
    @(negedge clk);
    rst = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  initial begin
    int w;
    bit p0, p1;
    logic [AL-1:0] pd0, pd1;
    logic [WW-1:0] px0, px1, saved5;

    for (int i = 0; i < 16; i++) begin rf_m[i] = '0; rf_dut[i] = '0; end
    model_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;

    // Single request, expected on the write port one cycle later
    reset_dut();
    drive("single_r0", 1'b0, 1'b1, 4'd3, 32'hAA, 1'b0, '0, '0, w);
    check("single_r0.dest3", wr_dest, 4'd3);
    check("single_r0.prio1", prio, 1'b1);

    // Continuous contention alternates, starting with r0
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive("alt", 1'b0, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, w);
      check("alt.dest_seq", wr_dest, (i % 2 == 0) ? 4'd1 : 4'd2);
    end
    check("alt.cnt4", conflict_cnt, 8'd4);

    // Hold freezes grants, prio and the contention counter
    for (int i = 0; i < 3; i++)
      drive("hold", 1'b1, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, w);
    drive("hold_rel", 1'b0, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, w);
    check("hold_rel.winner_r0", w, 0);

    // Counter saturation
    reset_dut();
    for (int i = 0; i < 300; i++)
      drive("sat", 1'b0, 1'b1, 4'(i), 32'(i), 1'b1, 4'(i + 1), 32'(i * 3), w);
    check("sat.cnt255", conflict_cnt, 8'd255);
    idle(2);

    // Same destination from both requesters with prio=1: r1 then r0, r0's value wins
    reset_dut();
    drive("pre7", 1'b0, 1'b1, 4'd0, 32'h77, 1'b0, '0, '0, w);
    drive("same7", 1'b0, 1'b1, 4'd7, 32'h1, 1'b1, 4'd7, 32'h2, w);
    check("same7.first_r1", w, 1);
    drive("same7b", 1'b0, 1'b1, 4'd7, 32'h1, 1'b0, '0, '0, w);
    idle(2);
    check("same7.reg7", rf_dut[7], 32'h1);
    check("addr0.reg0", rf_dut[0], 32'h77);

    // Async reset between handshake and the capturing edge: write never happens
    saved5 = rf_dut[5];
    @(negedge clk);
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_dest = 4'd5; r1_data = 32'h55;
    #1;
    check("async.r1_ready", r1_ready, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async.r1_ready_rst", r1_ready, 1'b0);
    check_outputs("async_imm");
    @(posedge clk);
    #1;
    check_outputs("async_edge");
    @(negedge clk);
    rst = 1'b0;
    r1_valid = 1'b0;
    idle(1);
    check("async.reg5", rf_dut[5], saved5);
    drive("async_post", 1'b0, 1'b1, 4'd4, 32'h44, 1'b1, 4'd6, 32'h66, w);
    check("async_post.winner_r0", w, 0);

    // Reset while a registered write is already on the port
    drive("mid", 1'b0, 1'b0, '0, '0, 1'b1, 4'd12, 32'hC0FFEE, w);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    r1_valid = 1'b0;
    idle(1);

    // Randomized traffic; requesters keep requests stable until accepted
    p0 = 1'b0; p1 = 1'b0;
    pd0 = '0; pd1 = '0; px0 = '0; px1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!p0 && $urandom_range(9) < 7) begin
        p0 = 1'b1; pd0 = 4'($urandom); px0 = $urandom;
      end
      if (!p1 && $urandom_range(9) < 6) begin
        p1 = 1'b1; pd1 = 4'($urandom); px1 = $urandom;
      end
      drive("rand", $urandom_range(9) < 2, p0, pd0, px0, p1, pd1, px1, w);
      if (w == 0) p0 = 1'b0;
      if (w == 1) p1 = 1'b0;
    end
    idle(2);
    for (int i = 0; i < 16; i++) check($sformatf("rf[%0d]", i), rf_dut[i], rf_m[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
